retire_trace_buffer: RTL and testbench

Synthesizable retirement-trace capture for the 16-bit single-cycle CPU. Sits directly downstream of the `cpu` top level, consuming its per-cycle retirement signals (PC, instruction, register write, memory access, halt). It classifies each retired instruction into a numbered trace record and buffers records in a FIFO drained over a valid/ready port. It also implements run-length watchdog and halt/drain status, so hardware runs can produce the same INUM trace as simulation.

---
 rtl/trace_pkg.sv | 49 ++++
 rtl/trace_fifo.sv | 57 +++++
 rtl/retire_trace_buffer.sv | 141 ++++++++++++++
 tb/tb_retire_trace_buffer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the retirement trace buffer: record kinds, run state and
// the packed trace record carried through the FIFO.
package trace_pkg;

    typedef enum logic [2:0] {
        KIND_REG   = 3'd0,
        KIND_LOAD  = 3'd1,
        KIND_STORE = 3'd2,
        KIND_OTHER = 3'd3,
        KIND_HALT  = 3'd4
    } kind_e;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_e;

    typedef struct packed {
        kind_e       kind;
        logic [15:0] inum;
        logic [15:0] pc;
        logic [15:0] inst;
        logic [3:0]  dst_reg;
        logic [15:0] value;
        logic [15:0] addr;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

    // Register writes outrank halt, which outranks a plain store.
    function automatic kind_e classify(input logic regwrite, input logic memread,
                                       input logic hlt, input logic memwrite);
        kind_e k;
        if (regwrite && memread) begin
            k = KIND_LOAD;
        end else if (regwrite) begin
            k = KIND_REG;
        end else if (hlt) begin
            k = KIND_HALT;
        end else if (memwrite) begin
            k = KIND_STORE;
        end else begin
            k = KIND_OTHER;
        end
        return k;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Register-array FIFO; the head is read straight from storage so consumers see
// a registered value, forced to zero while empty.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 87
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      count_s;
    logic             do_pop_s;
    logic             do_push_s;

    assign count_s   = wr_ptr_r - rd_ptr_r;
    assign empty     = (count_s == '0);
    assign full      = (count_s == FULL_CNT);
    assign do_pop_s  = pop & ~empty;
    // A same-cycle pop frees the slot a full-FIFO push needs.
    assign do_push_s = push & (~full | do_pop_s);
    assign head_data = empty ? '0 : mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE;
            end
        end
    end

    // Storage needs no reset: stale entries are never visible past the pointers.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// Classifies each retired instruction into a numbered trace record, buffers it,
// and tracks halt / watchdog run state.
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ret_valid,
    input  logic [15:0] ret_pc,
    input  logic [15:0] ret_inst,
    input  logic        ret_regwrite,
    input  logic [3:0]  ret_dst_reg,
    input  logic [15:0] ret_dst_data,
    input  logic        ret_memread,
    input  logic        ret_memwrite,
    input  logic [15:0] ret_mem_addr,
    input  logic [15:0] ret_mem_data,
    input  logic        ret_hlt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_kind,
    output logic [15:0] out_inum,
    output logic [15:0] out_pc,
    output logic [15:0] out_inst,
    output logic [3:0]  out_reg,
    output logic [15:0] out_value,
    output logic [15:0] out_addr,
    output logic        overflow,
    output logic        timeout,
    output logic        done
);
    localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);

    state_e             state_r;
    logic [31:0]        cyc_cnt_r;
    logic [15:0]        inum_r;
    logic               overflow_r;
    kind_e              kind_s;
    trace_rec_t         rec_s;
    trace_rec_t         head_s;
    logic [REC_W-1:0]   head_vec_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               pop_s;
    logic               trip_s;
    logic               capture_s;

    assign trip_s    = (cyc_cnt_r == TIMEOUT_C);
    assign pop_s     = ~fifo_empty_s & out_ready;
    // On the watchdog cycle only a halt is still captured.
    assign capture_s = (state_r == ST_RUN) & ret_valid & (~trip_s | (kind_s == KIND_HALT));

    // Record assembly from the retirement signals.
    always_comb begin
        kind_s       = classify(ret_regwrite, ret_memread, ret_hlt, ret_memwrite);
        rec_s        = '0;
        rec_s.kind   = kind_s;
        rec_s.inum   = inum_r;
        rec_s.pc     = ret_pc;
        rec_s.inst   = ret_inst;
        case (kind_s)
            KIND_REG: begin
                rec_s.dst_reg = ret_dst_reg;
                rec_s.value   = ret_dst_data;
            end
            KIND_LOAD: begin
                rec_s.dst_reg = ret_dst_reg;
                rec_s.value   = ret_dst_data;
                rec_s.addr    = ret_mem_addr;
            end
            KIND_STORE: begin
                rec_s.value = ret_mem_data;
                rec_s.addr  = ret_mem_addr;
            end
            default: begin
                rec_s.value = 16'h0000;
            end
        endcase
    end

    // Run-state FSM, cycle and instruction counters, sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            cyc_cnt_r  <= 32'd0;
            inum_r     <= 16'd0;
            overflow_r <= 1'b0;
        end else begin
            if (capture_s) begin
                inum_r <= inum_r + 16'd1;
            end
            if (capture_s & fifo_full_s & ~pop_s) begin
                overflow_r <= 1'b1;
            end
            case (state_r)
                ST_RUN: begin
                    cyc_cnt_r <= cyc_cnt_r + 32'd1;
                    if (capture_s && (kind_s == KIND_HALT)) begin
                        state_r <= ST_HALTED;
                    end else if (trip_s) begin
                        state_r <= ST_TIMEOUT;
                    end
                end
                default: begin
                    state_r <= state_r;
                end
            endcase
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture_s),
        .pop       (pop_s),
        .push_data (rec_s),
        .head_data (head_vec_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign head_s    = trace_rec_t'(head_vec_s);
    assign out_valid = ~fifo_empty_s;
    assign out_kind  = head_s.kind;
    assign out_inum  = head_s.inum;
    assign out_pc    = head_s.pc;
    assign out_inst  = head_s.inst;
    assign out_reg   = head_s.dst_reg;
    assign out_value = head_s.value;
    assign out_addr  = head_s.addr;
    assign overflow  = overflow_r;
    assign timeout   = (state_r == ST_TIMEOUT);
    assign done      = (state_r != ST_RUN) & fifo_empty_s;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Randomized and directed bench for retire_trace_buffer against a queue-based
// reference model of the trace rules.
module tb_retire_trace_buffer;
    localparam int DEPTH = 16;
    localparam int TMO   = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        ret_valid, ret_regwrite, ret_memread, ret_memwrite, ret_hlt;
    logic [15:0] ret_pc, ret_inst, ret_dst_data, ret_mem_addr, ret_mem_data;
    logic [3:0]  ret_dst_reg;
    logic        out_valid, out_ready, overflow, timeout, done;
    logic [2:0]  out_kind;
    logic [15:0] out_inum, out_pc, out_inst, out_value, out_addr;
    logic [3:0]  out_reg;

    always #5 clk = ~clk;

    retire_trace_buffer #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst),
        .ret_regwrite(ret_regwrite), .ret_dst_reg(ret_dst_reg), .ret_dst_data(ret_dst_data),
        .ret_memread(ret_memread), .ret_memwrite(ret_memwrite), .ret_mem_addr(ret_mem_addr),
        .ret_mem_data(ret_mem_data), .ret_hlt(ret_hlt), .out_valid(out_valid),
        .out_ready(out_ready), .out_kind(out_kind), .out_inum(out_inum), .out_pc(out_pc),
        .out_inst(out_inst), .out_reg(out_reg), .out_value(out_value), .out_addr(out_addr),
        .overflow(overflow), .timeout(timeout), .done(done)
    );

    int vectors = 0;
    int miscompares = 0;
    int xfers = 0;
    logic [15:0] last_inum;
    logic [2:0]  last_kind;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a queue of records plus run state (0 run, 1 halted, 2 timeout).
    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] inum, pc, inst;
        logic [3:0]  rg;
        logic [15:0] value, addr;
    } mrec_t;
    mrec_t       mq[$];
    int          m_state;
    int          m_cyc;
    logic [15:0] m_inum;
    bit          m_ovf;

    task automatic model_step();
        mrec_t r;
        bit trip;
        if (rst) begin
            mq.delete();
            m_state = 0; m_cyc = 0; m_inum = 16'd0; m_ovf = 1'b0;
            return;
        end
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (m_state == 0) begin
            trip = (m_cyc == TMO);
            if (ret_valid) begin
                r = '0;
                r.pc = ret_pc;
                r.inst = ret_inst;
                if (ret_regwrite) begin
                    r.kind = ret_memread ? 3'd1 : 3'd0;
                    r.rg = ret_dst_reg;
                    r.value = ret_dst_data;
                    if (ret_memread) r.addr = ret_mem_addr;
                end else if (ret_hlt) begin
                    r.kind = 3'd4;
                end else if (ret_memwrite) begin
                    r.kind = 3'd2;
                    r.value = ret_mem_data;
                    r.addr = ret_mem_addr;
                end else begin
                    r.kind = 3'd3;
                end
                if (!trip || r.kind == 3'd4) begin
                    r.inum = m_inum;
                    m_inum = m_inum + 16'd1;
                    if (mq.size() < DEPTH) mq.push_back(r);
                    else m_ovf = 1'b1;
                    if (r.kind == 3'd4) m_state = 1;
                end
            end
            if (m_state == 0 && trip) m_state = 2;
            m_cyc++;
        end
    endtask

    task automatic compare_all();
        mrec_t h;
        h = (mq.size() > 0) ? mq[0] : '0;
        check_eq("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        check_eq("out_kind", 32'(out_kind), 32'(h.kind));
        check_eq("out_inum", 32'(out_inum), 32'(h.inum));
        check_eq("out_pc", 32'(out_pc), 32'(h.pc));
        check_eq("out_inst", 32'(out_inst), 32'(h.inst));
        check_eq("out_reg", 32'(out_reg), 32'(h.rg));
        check_eq("out_value", 32'(out_value), 32'(h.value));
        check_eq("out_addr", 32'(out_addr), 32'(h.addr));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("timeout", 32'(timeout), 32'(m_state == 2));
        check_eq("done", 32'(done), 32'(m_state != 0 && mq.size() == 0));
    endtask

    // One clock: note any DUT transfer, step the model on the edge, compare on the falling edge.
    task automatic tick();
        if (out_valid === 1'b1 && out_ready) begin
            xfers++;
            last_inum = out_inum;
            last_kind = out_kind;
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        ret_valid = 1'b0; ret_pc = 16'h0; ret_inst = 16'h0; ret_regwrite = 1'b0;
        ret_dst_reg = 4'h0; ret_dst_data = 16'h0; ret_memread = 1'b0; ret_memwrite = 1'b0;
        ret_mem_addr = 16'h0; ret_mem_data = 16'h0; ret_hlt = 1'b0;
    endtask

    task automatic rand_inputs(input int hlt_pct);
        ret_valid    = ($urandom_range(0, 3) != 0);
        ret_pc       = 16'($urandom);
        ret_inst     = 16'($urandom);
        ret_regwrite = 1'($urandom_range(0, 1));
        ret_dst_reg  = 4'($urandom);
        ret_dst_data = 16'($urandom);
        ret_memread  = ($urandom_range(0, 2) == 0);
        ret_memwrite = ($urandom_range(0, 2) == 0);
        ret_mem_addr = 16'($urandom);
        ret_mem_data = 16'($urandom);
        ret_hlt      = ($urandom_range(0, 99) < hlt_pct);
    endtask

    task automatic retire_reg(input logic [15:0] pc, input logic [3:0] rd, input logic [15:0] data);
        idle();
        ret_valid = 1'b1; ret_pc = pc; ret_inst = 16'h1000 | pc; ret_regwrite = 1'b1;
        ret_dst_reg = rd; ret_dst_data = data;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b0; idle();
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_tmo", 32'(timeout), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);

        // ADD R3 = 0x0012 at PC 0
        out_ready = 1'b1;
        retire_reg(16'h0000, 4'd3, 16'h0012);
        tick(); idle();
        check_eq("add_kind", 32'(out_kind), 32'd0);
        check_eq("add_inum", 32'(out_inum), 32'd0);
        check_eq("add_reg", 32'(out_reg), 32'd3);
        check_eq("add_value", 32'(out_value), 32'h0012);
        tick();

        // Load then store
        do_reset(); out_ready = 1'b0;
        idle(); ret_valid = 1'b1; ret_pc = 16'h0004; ret_regwrite = 1'b1; ret_memread = 1'b1;
        ret_dst_reg = 4'd5; ret_dst_data = 16'hBEEF; ret_mem_addr = 16'h0040;
        tick();
        idle(); ret_valid = 1'b1; ret_pc = 16'h0006; ret_memwrite = 1'b1;
        ret_mem_addr = 16'h0042; ret_mem_data = 16'h1234;
        tick(); idle();
        check_eq("ld_kind", 32'(out_kind), 32'd1);
        check_eq("ld_fields", {out_reg, out_value, out_addr[11:0]}, {4'd5, 16'hBEEF, 12'h040});
        out_ready = 1'b1;
        tick();
        check_eq("st_kind", 32'(out_kind), 32'd2);
        check_eq("st_fields", {out_inum, out_value}, {16'd1, 16'h1234});
        check_eq("st_addr", 32'(out_addr), 32'h0042);
        tick();

        // Overflow: DEPTH+2 captures with no drain
        do_reset(); out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            retire_reg(16'(2 * i), 4'(i), 16'($urandom));
            tick();
        end
        idle();
        check_eq("ovf_set", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check_eq("drain_inum", 32'(out_inum), 32'(i));
            tick();
        end
        check_eq("drain_empty", 32'(out_valid), 32'd0);
        retire_reg(16'h0100, 4'd1, 16'h0001);
        tick(); idle();
        check_eq("gap_inum", 32'(out_inum), 32'd18);
        tick();

        // Halt after three instructions
        do_reset(); out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            retire_reg(16'(2 * i), 4'd2, 16'(i));
            tick();
        end
        idle(); ret_valid = 1'b1; ret_pc = 16'h0020; ret_inst = 16'hF000; ret_hlt = 1'b1;
        tick();
        rand_inputs(0); ret_valid = 1'b1;
        check_eq("hlt_kind", 32'(out_kind), 32'd4);
        check_eq("hlt_inum", 32'(out_inum), 32'd3);
        check_eq("hlt_pc", 32'(out_pc), 32'h0020);
        check_eq("hlt_notdone", 32'(done), 32'd0);
        tick();
        check_eq("hlt_done", 32'(done), 32'd1);
        for (int i = 0; i < 4; i++) begin
            rand_inputs(0); ret_valid = 1'b1;
            tick();
        end
        check_eq("hlt_ignored", 32'(out_valid), 32'd0);

        // Watchdog with no halt
        do_reset(); xfers = 0;
        for (int i = 0; i < TMO + 5; i++) begin
            rand_inputs(0); ret_valid = 1'b1;
            out_ready = ($urandom_range(0, 9) != 0);
            tick();
        end
        idle(); out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 4; i++) tick();
        check_eq("tmo_records", 32'(xfers), 32'(TMO));
        check_eq("tmo_flag", 32'(timeout), 32'd1);
        check_eq("tmo_done", 32'(done), 32'd1);

        // Halt on the trip cycle
        do_reset(); xfers = 0; out_ready = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            retire_reg(16'(i), 4'd7, 16'(i));
            tick();
        end
        idle(); ret_valid = 1'b1; ret_hlt = 1'b1; ret_pc = 16'h0777;
        tick();
        idle();
        for (int i = 0; i < 4; i++) tick();
        check_eq("trip_hlt_tmo", 32'(timeout), 32'd0);
        check_eq("trip_hlt_done", 32'(done), 32'd1);
        check_eq("trip_hlt_kind", 32'(last_kind), 32'd4);
        check_eq("trip_hlt_inum", 32'(last_inum), 32'(TMO));

        // Reset with five records queued and overflow set
        do_reset(); out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            retire_reg(16'(i), 4'd1, 16'(i));
            tick();
        end
        idle(); out_ready = 1'b1;
        for (int i = 0; i < DEPTH - 5; i++) tick();
        out_ready = 1'b0;
        check_eq("pre_rst_ovf", 32'(overflow), 32'd1);
        check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        do_reset();
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_ovf", 32'(overflow), 32'd0);
        retire_reg(16'h0050, 4'd9, 16'h0099);
        tick(); idle();
        check_eq("mid_rst_inum", 32'(out_inum), 32'd0);
        check_eq("mid_rst_new", 32'(out_valid), 32'd1);

        // Random runs
        for (int run = 0; run < 8; run++) begin
            do_reset();
            for (int c = 0; c < 200; c++) begin
                rand_inputs(run % 4);
                out_ready = ($urandom_range(0, 3) < 1 + (run % 3));
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
